// File: rtl/edsac_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : edsac_pkg
//  Description : Shared memory-geometry defaults and arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package edsac_pkg;

    localparam int ABITS_DEF = 9;
    localparam int DBITS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (CPU / loader) arbiter in front of a single memory,
//                fixed-priority or round-robin, non-pre-emptive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import edsac_pkg::*;
#(
    parameter int ABITS  = ABITS_DEF,
    parameter int DBITS  = DBITS_DEF,
    parameter int RROBIN = 1
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_rd,
    input  logic             a_wr,
    input  logic [ABITS-1:0] a_addr,
    input  logic [DBITS-1:0] a_wdata,
    output logic [DBITS-1:0] a_rdata,
    output logic             a_wait,

    input  logic             b_rd,
    input  logic             b_wr,
    input  logic [ABITS-1:0] b_addr,
    input  logic [DBITS-1:0] b_wdata,
    output logic [DBITS-1:0] b_rdata,
    output logic             b_wait,

    output logic             mem_rd,
    output logic             mem_wr,
    output logic [ABITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_d,
    input  logic [DBITS-1:0] mem_q,
    input  logic             mem_wait,

    output logic             gnt_a,
    output logic             gnt_b
);

    arb_state_e state_q, state_d;
    // High when port B was the last port to complete an access.
    logic       last_b_q, last_b_d;

    logic w_a_req;
    logic w_b_req;
    logic w_tie_to_a;

    assign w_a_req = a_rd | a_wr;
    assign w_b_req = b_rd | b_wr;
    assign w_tie_to_a = (RROBIN == 0) ? 1'b1 : last_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        unique case (state_q)
            IDLE: begin
                if (w_a_req && w_b_req) begin
                    state_d = w_tie_to_a ? GNT_A : GNT_B;
                end else if (w_a_req) begin
                    state_d = GNT_A;
                end else if (w_b_req) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                // A dropped its request without completing: release, keep pointer.
                if (!w_a_req) begin
                    state_d = IDLE;
                end else if (!mem_wait) begin
                    state_d  = w_b_req ? GNT_B : IDLE;
                    last_b_d = 1'b0;
                end
            end
            GNT_B: begin
                if (!w_b_req) begin
                    state_d = IDLE;
                end else if (!mem_wait) begin
                    state_d  = w_a_req ? GNT_A : IDLE;
                    last_b_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_d    = '0;
        unique case (state_q)
            GNT_A: begin
                // Simultaneous read and write strobes are treated as a write.
                mem_rd   = a_rd & ~a_wr;
                mem_wr   = a_wr;
                mem_addr = a_addr;
                mem_d    = a_wdata;
            end
            GNT_B: begin
                mem_rd   = b_rd & ~b_wr;
                mem_wr   = b_wr;
                mem_addr = b_addr;
                mem_d    = b_wdata;
            end
            default: begin
                mem_rd   = 1'b0;
                mem_wr   = 1'b0;
                mem_addr = '0;
                mem_d    = '0;
            end
        endcase
    end

    assign gnt_a   = (state_q == GNT_A);
    assign gnt_b   = (state_q == GNT_B);

    assign a_wait  = w_a_req & ~(gnt_a & ~mem_wait);
    assign b_wait  = w_b_req & ~(gnt_b & ~mem_wait);

    assign a_rdata = mem_q;
    assign b_rdata = mem_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed, table-driven bench for mem_arbiter (round-robin and
//                fixed-priority instances sharing one stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_rd, a_wr, b_rd, b_wr, mem_wait;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, mem_q;

    logic [DW-1:0] a_rdata, b_rdata, mem_d;
    logic [AW-1:0] mem_addr;
    logic          a_wait, b_wait, mem_rd, mem_wr, gnt_a, gnt_b;

    logic [DW-1:0] a_rdata_f, b_rdata_f, mem_d_f;
    logic [AW-1:0] mem_addr_f;
    logic          a_wait_f, b_wait_f, mem_rd_f, mem_wr_f, gnt_a_f, gnt_b_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ABITS(AW), .DBITS(DW), .RROBIN(1)) u_rr (
        .clk(clk), .rst(rst),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_wait(a_wait),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_wait(b_wait),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_d(mem_d),
        .mem_q(mem_q), .mem_wait(mem_wait),
        .gnt_a(gnt_a), .gnt_b(gnt_b)
    );

    mem_arbiter #(.ABITS(AW), .DBITS(DW), .RROBIN(0)) u_fix (
        .clk(clk), .rst(rst),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata_f), .a_wait(a_wait_f),
        .b_rd(b_rd), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata_f), .b_wait(b_wait_f),
        .mem_rd(mem_rd_f), .mem_wr(mem_wr_f), .mem_addr(mem_addr_f), .mem_d(mem_d_f),
        .mem_q(mem_q), .mem_wait(mem_wait),
        .gnt_a(gnt_a_f), .gnt_b(gnt_b_f)
    );

    typedef struct {
        logic          a_rd, a_wr;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wdata;
        logic          b_rd, b_wr;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wdata;
        logic          mem_wait;
        logic [DW-1:0] mem_q;
        logic          gnt_a, gnt_b, mem_rd, mem_wr;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_d;
        logic          a_wait, b_wait;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic ard, input logic awr, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
        input logic brd, input logic bwr, input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
        input logic mw, input logic [DW-1:0] mq,
        input logic ga, input logic gb, input logic mrd, input logic mwr,
        input logic [AW-1:0] mad, input logic [DW-1:0] md, input logic aw, input logic bw);
        vec_t v;
        v.a_rd = ard; v.a_wr = awr; v.a_addr = aad; v.a_wdata = awd;
        v.b_rd = brd; v.b_wr = bwr; v.b_addr = bad; v.b_wdata = bwd;
        v.mem_wait = mw; v.mem_q = mq;
        v.gnt_a = ga; v.gnt_b = gb; v.mem_rd = mrd; v.mem_wr = mwr;
        v.mem_addr = mad; v.mem_d = md; v.a_wait = aw; v.b_wait = bw;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        mem_wait = 0; mem_q = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] got, exp;

        //   a: rd wr addr   wdata    b: rd wr addr   wdata    mw  mq       | ga gb rd wr addr   d        aw bw
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0, 16'h1111, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 1);
        add(1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0, 16'h1111, 1, 0, 1, 0, 9'h010, 16'h0000, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 1, 0, 9'h020, 16'h0000, 0, 16'h2222, 0, 1, 1, 0, 9'h020, 16'h0000, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(1, 0, 9'h011, 16'h0000, 0, 1, 9'h021, 16'h5555, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 1);
        add(1, 0, 9'h011, 16'h0000, 0, 1, 9'h021, 16'h5555, 0, 16'h0000, 1, 0, 1, 0, 9'h011, 16'h0000, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h021, 16'h5555, 0, 16'h0000, 0, 1, 0, 1, 9'h021, 16'h5555, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(1, 0, 9'h012, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'hA5A5, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 0);
        add(1, 0, 9'h012, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'hA5A5, 1, 0, 1, 0, 9'h012, 16'h0000, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h1FF, 16'hBEEF, 1, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h1FF, 16'hBEEF, 1, 16'h0000, 0, 1, 0, 1, 9'h1FF, 16'hBEEF, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h1FF, 16'hBEEF, 1, 16'h0000, 0, 1, 0, 1, 9'h1FF, 16'hBEEF, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h1FF, 16'hBEEF, 1, 16'h0000, 0, 1, 0, 1, 9'h1FF, 16'hBEEF, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 1, 9'h1FF, 16'hBEEF, 0, 16'h0000, 0, 1, 0, 1, 9'h1FF, 16'hBEEF, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(1, 1, 9'h0AA, 16'h1234, 0, 0, 9'h000, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 0);
        add(1, 1, 9'h0AA, 16'h1234, 0, 0, 9'h000, 16'h0000, 1, 16'h0000, 1, 0, 0, 1, 9'h0AA, 16'h1234, 1, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 1, 16'h0000, 1, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(1, 0, 9'h001, 16'h0000, 1, 0, 9'h002, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 1, 1);
        add(1, 0, 9'h001, 16'h0000, 1, 0, 9'h002, 16'h0000, 0, 16'h0000, 1, 0, 1, 0, 9'h001, 16'h0000, 0, 1);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 9'h000, 16'h0000, 0, 0);
        add(0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 9'h000, 16'h0000, 0, 0);

        // Reset held low: a pending request must not reach the memory.
        rst = 0;
        idle_inputs();
        a_rd = 1; a_addr = 9'h012;
        repeat (2) next_cycle();
        chk("reset_rr", {60'd0, gnt_a, gnt_b, mem_rd, mem_wr}, 64'd0);
        chk("reset_fix", {60'd0, gnt_a_f, gnt_b_f, mem_rd_f, mem_wr_f}, 64'd0);
        a_rd = 0; a_addr = '0;
        next_cycle();
        rst = 1;

        foreach (tbl[i]) begin
            a_rd = tbl[i].a_rd; a_wr = tbl[i].a_wr; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wdata;
            b_rd = tbl[i].b_rd; b_wr = tbl[i].b_wr; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wdata;
            mem_wait = tbl[i].mem_wait; mem_q = tbl[i].mem_q;
            #2;
            got = {1'b0, gnt_a, gnt_b, mem_rd, mem_wr, a_wait, b_wait, mem_addr, mem_d, a_rdata, b_rdata};
            exp = {1'b0, tbl[i].gnt_a, tbl[i].gnt_b, tbl[i].mem_rd, tbl[i].mem_wr,
                   tbl[i].a_wait, tbl[i].b_wait, tbl[i].mem_addr, tbl[i].mem_d,
                   tbl[i].mem_q, tbl[i].mem_q};
            chk($sformatf("vec%0d", i), got, exp);
            next_cycle();
        end

        // Asynchronous reset in the middle of a stalled B write; pointer was A.
        idle_inputs();
        b_wr = 1; b_addr = 9'h033; b_wdata = 16'h7777; mem_wait = 1;
        next_cycle();
        #1;
        chk("pre_reset_gntb", {62'd0, gnt_b, mem_wr}, 64'h3);
        rst = 0;
        #1;
        chk("async_reset", {60'd0, gnt_a, gnt_b, mem_rd, mem_wr}, 64'd0);
        chk("async_reset_fix", {60'd0, gnt_a_f, gnt_b_f, mem_rd_f, mem_wr_f}, 64'd0);
        idle_inputs();
        next_cycle();
        rst = 1;
        a_rd = 1; a_addr = 9'h044; b_rd = 1; b_addr = 9'h055;
        #1;
        chk("post_reset_idle", {62'd0, gnt_a, gnt_b}, 64'd0);
        next_cycle();
        #1;
        chk("post_reset_tie", {53'd0, gnt_a, gnt_b, mem_addr}, {53'd0, 2'b10, 9'h044});
        next_cycle();
        a_rd = 0; a_addr = '0;
        #1;
        chk("back_to_back_b", {53'd0, gnt_a, gnt_b, mem_addr}, {53'd0, 2'b01, 9'h055});
        next_cycle();
        b_rd = 0; b_addr = '0;
        #1;
        chk("after_b_idle", {62'd0, gnt_a, gnt_b}, 64'd0);

        // A served alone, then a tie: round-robin favours B, fixed priority favours A.
        a_rd = 1; a_addr = 9'h066;
        repeat (2) next_cycle();
        a_rd = 0; a_addr = '0;
        next_cycle();
        a_rd = 1; a_addr = 9'h077; b_rd = 1; b_addr = 9'h088;
        next_cycle();
        #1;
        chk("rr_tie_after_a", {53'd0, gnt_a, gnt_b, mem_addr}, {53'd0, 2'b01, 9'h088});
        chk("fix_tie_after_a", {53'd0, gnt_a_f, gnt_b_f, mem_addr_f}, {53'd0, 2'b10, 9'h077});
        next_cycle();
        idle_inputs();
        next_cycle();
        b_rd = 1; b_addr = 9'h099;
        next_cycle();
        #1;
        chk("fix_b_alone", {53'd0, gnt_a_f, gnt_b_f, mem_addr_f}, {53'd0, 2'b01, 9'h099});
        next_cycle();
        idle_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
